// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pkg                                                      |
// | Description : Shared ALU definitions: command codes, default data width    |
// |               and the sequential-divider state encoding.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int DATA_WIDTH = 16;

  localparam logic [2:0] CMD_ADD = 3'd1;
  localparam logic [2:0] CMD_SUB = 3'd2;
  localparam logic [2:0] CMD_MUL = 3'd3;
  localparam logic [2:0] CMD_DIV = 3'd4;
  localparam logic [2:0] CMD_MOD = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_step                                                     |
// | Description : One combinational restoring-division iteration.             |
// |               {r,q} is shifted left by one, the divisor is trial-          |
// |               subtracted from the widened partial remainder and the        |
// |               difference is kept only when it is non-negative.             |
// | Ports       : r, q, d          - partial remainder, quotient, divisor      |
// |               r_next, q_next   - values after this iteration              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_neg;

  // The shifted remainder needs one extra bit; a true non-negative difference
  // is always below the divisor, so bit WIDTH doubles as the sign.
  assign w_shift = {r, q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, d};
  assign w_neg   = w_diff[WIDTH];

  assign r_next = w_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~w_neg};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_divider                                                  |
// | Description : Iterative restoring divider for the ALU DIV/MOD channels,   |
// |               driven through a start/done handshake.                       |
// |               Build option SIGNED_DIV_EN: two's-complement operands,       |
// |               truncating division with overflow on MIN / -1.              |
// | Ports       : clk, rst_n          - clock, async active-low reset         |
// |               start               - request, honoured in IDLE/FIN only     |
// |               dividend, divisor   - operands, captured on accepted start   |
// |               busy                - iterations in progress                 |
// |               done                - one-cycle result-valid pulse           |
// |               quotient, remainder - registered results                     |
// |               div_by_zero         - last operation had a zero divisor      |
// |               overflow            - signed overflow (0 in unsigned build)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic             w_accept;
  logic             w_zero_div;
  logic             w_last;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc_r;
  logic [WIDTH-1:0] r_acc_q;
  logic [WIDTH-1:0] r_den;
  logic [WIDTH-1:0] w_step_r;
  logic [WIDTH-1:0] w_step_q;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_rem_fin;
  logic             w_ovf_fin;

  logic             r_zero_pend;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic             r_ovf;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;

  // --------------------------------------------------------------------------
  // Operand conditioning and result fix-up
  // --------------------------------------------------------------------------
`ifdef SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;
  logic r_ovf_case;

  assign w_dvd_mag = dividend[WIDTH-1] ? (WIDTH'(0) - dividend) : dividend;
  assign w_dvs_mag = divisor[WIDTH-1]  ? (WIDTH'(0) - divisor)  : divisor;

  // MIN / -1 needs no special datapath: |MIN| / 1 = MIN as an unsigned
  // magnitude, and negating it (signs agree, so no negation) leaves MIN.
  assign w_quo_fin = r_neg_q ? (WIDTH'(0) - r_acc_q) : r_acc_q;
  assign w_rem_fin = r_neg_r ? (WIDTH'(0) - r_acc_r) : r_acc_r;
  assign w_ovf_fin = r_ovf_case;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_ovf_case <= 1'b0;
    end else if (w_accept) begin
      r_neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r    <= dividend[WIDTH-1];
      r_ovf_case <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_quo_fin = r_acc_q;
  assign w_rem_fin = r_acc_r;
  assign w_ovf_fin = 1'b0;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r      (r_acc_r),
    .q      (r_acc_q),
    .d      (r_den),
    .r_next (w_step_r),
    .q_next (w_step_q)
  );

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_zero_div  = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          if (divisor == '0) begin
            w_zero_div  = 1'b1;
            w_state_nxt = ST_FIN;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Counter values 0..WIDTH-1 are the iterations; WIDTH is the
        // transfer cycle that publishes the result.
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = ST_FIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc_r     <= '0;
      r_acc_q     <= '0;
      r_den       <= '0;
      r_zero_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_quo       <= '0;
      r_rem       <= '0;
    end else begin
      r_done      <= 1'b0;
      // busy covers the iteration cycles only, not the accept or transfer cycle
      r_busy      <= (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
      r_zero_pend <= w_zero_div;

      if (w_accept) begin
        r_acc_r <= '0;
        r_acc_q <= w_dvd_mag;
        r_den   <= w_dvs_mag;
        r_cnt   <= '0;
      end else if (w_zero_div) begin
        // raw dividend is parked here for the divide-by-zero remainder
        r_acc_q <= dividend;
      end else if ((r_state == ST_RUN) && !w_last) begin
        r_acc_r <= w_step_r;
        r_acc_q <= w_step_q;
        r_cnt   <= r_cnt + 1'b1;
      end

      if (r_zero_pend) begin
        r_quo  <= '1;
        r_rem  <= r_acc_q;
        r_dbz  <= 1'b1;
        r_ovf  <= 1'b0;
        r_done <= 1'b1;
      end else if (w_last) begin
        r_quo  <= w_quo_fin;
        r_rem  <= w_rem_fin;
        r_dbz  <= 1'b0;
        r_ovf  <= w_ovf_fin;
        r_done <= 1'b1;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_divider                                               |
// | Description : Scoreboard bench for seq_divider. Define SIGNED_DIV_EN for   |
// |               both RTL and bench to exercise the signed build.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  seq_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           cyc;
    int           busy_n;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           busy_cnt = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: result and the cycle count at which done must appear.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    exp_t e;
    e.dbz    = 1'b0;
    e.ovf    = 1'b0;
    e.cyc    = c + 1 + ((b == 0) ? 1 : W + 1);
    e.busy_n = (b == 0) ? 0 : W;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end
`ifdef SIGNED_DIV_EN
    else if (a == 16'h8000 && b == 16'hFFFF) begin
      e.q   = 16'h8000;
      e.r   = '0;
      e.ovf = 1'b1;
    end else begin
      e.q = W'($signed(a) / $signed(b));
      e.r = W'($signed(a) % $signed(b));
    end
`else
    else begin
      e.q = a / b;
      e.r = a % b;
    end
`endif
    return e;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n && busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          check_eq("quotient", quotient, e.q);
          check_eq("remainder", remainder, e.r);
          check_eq("div_by_zero", div_by_zero, e.dbz);
          check_eq("overflow", overflow, e.ovf);
          check_eq("done_cycle", cyc, e.cyc);
          check_eq("busy_at_done", busy, 0);
          check_eq("busy_cycles", busy_cnt, e.busy_n);
          last_q = e.q;
          last_r = e.r;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b, cyc));
    @(posedge clk);
    #2;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_done(input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(posedge clk);
      #2;
      seen = done;
    end
    if (!seen) check_eq("done_timeout", done, 1);
  endtask

  task automatic check_cleared();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_quotient", quotient, 0);
    check_eq("rst_remainder", remainder, 0);
    check_eq("rst_div_by_zero", div_by_zero, 0);
    check_eq("rst_overflow", overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_cleared();
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'd249, 16'd69);
    wait_done(40);

    @(negedge clk);
    issue(16'd32000, 16'd16001);
    wait_done(40);
    issue(16'd65535, 16'd1);           // start in the done cycle
    wait_done(40);

    @(negedge clk);
    issue(16'd100, 16'd0);
    wait_done(5);
    @(negedge clk);
    issue(16'd10, 16'd3);
    wait_done(40);

    // Start while busy must be ignored
    @(negedge clk);
    issue(16'd249, 16'd69);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd7;
    divisor  = 16'd2;
    @(negedge clk);
    start    = 1'b0;
    wait_done(40);

    // Results hold in FIN
    repeat (5) @(negedge clk);
    check_eq("hold_quotient", quotient, last_q);
    check_eq("hold_remainder", remainder, last_r);

    // Reset in the middle of an operation
    @(negedge clk);
    issue(16'd249, 16'd69);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared();
    sb.delete();
    busy_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'd10, 16'd3);
    wait_done(40);

`ifdef SIGNED_DIV_EN
    @(negedge clk);
    issue(16'hFFF9, 16'd2);             // -7 / 2
    wait_done(40);
    @(negedge clk);
    issue(16'h8000, 16'hFFFF);          // MIN / -1
    wait_done(40);
    @(negedge clk);
    issue(16'd7, 16'hFFFE);             // 7 / -2
    wait_done(40);
`endif

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue(W'($urandom), (i == 2) ? 16'd0 : W'($urandom_range(1, 300)));
      wait_done(40);
    end

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider that fills the ALU's DIV (command 4) and MOD (command 5) result channels, which are currently grounded.
- It is the inverse operation of the array multiplier: it takes a dividend and divisor of WIDTH bits and returns quotient and remainder.
- It is multi-cycle, so the ALU wrapper drives it through a start/done handshake instead of selecting it combinationally.

Parameters:
- WIDTH, 16: operand, quotient and remainder width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  numerator; captured on the accepted start
- divisor  input  WIDTH  denominator; captured on the accepted start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when results become valid
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  error flag for the last completed operation
- overflow  output  1  signed overflow flag for the last operation; tied 0 without SIGNED_DIV_EN

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, quotient, remainder, div_by_zero and overflow are all 0. Any in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE or FIN, start=1, divisor!=0:
  - Capture the operands. Clear the partial remainder and iteration counter.
  - Go to RUN. busy=1 from the next cycle.
- IDLE or FIN, start=1, divisor==0:
  - Go directly to FIN.
  - On the next edge, set quotient = all-ones, remainder = dividend, div_by_zero=1 and pulse done.
  - Latency is 1 clock.
- RUN performs one restoring step per clock, for WIDTH clocks:
  - Shift {R,Q} left by 1.
  - Compute T = R - D at WIDTH+1 bits.
  - If T is non-negative, R=T and Q[0]=1. Otherwise keep R and set Q[0]=0.
- After the last step (counter = WIDTH-1):
  - Transfer Q and R to the outputs and clear div_by_zero and overflow.
  - Pulse done for exactly one cycle. Go to FIN with busy=0.
- Latency: done is high in the cycle that starts WIDTH+1 rising edges after the edge that sampled start. For WIDTH=16 that is 17 clocks.
- FIN behaves like IDLE and keeps the results. The outputs hold their values until the next accepted operation completes or a reset occurs.
- start while busy=1 is ignored and has no effect on the current operation.
- start asserted in the same cycle as done is accepted, so back-to-back operations are legal.
- Inputs may change after the accepted start without effect.
- Output registers change only on completion or reset. Intermediate values never appear on quotient or remainder.

Optional Feature:
- SIGNED_DIV_EN defined:
  - Operands are two's complement. Magnitudes are taken at capture and the same unsigned core is used.
  - The quotient is negated if the operand signs differ. The remainder takes the dividend's sign (truncation toward zero).
  - Sign fix-up is applied combinationally at the final transfer, so latency is unchanged.
  - Most-negative / -1: quotient = most-negative value, remainder = 0, overflow=1.
  - Divide-by-zero behaves as in the unsigned case, with remainder = raw dividend.
- SIGNED_DIV_EN undefined: unsigned only, and overflow is constant 0.

Decomposition:
- Shared ALU package (alu_pkg):
  - State enum for IDLE/RUN/FIN.
  - ALU command constants: CMD_ADD=1, CMD_SUB=2, CMD_MUL=3, CMD_DIV=4, CMD_MOD=5.
  - Default data width constant of 16.
- One sub-module: div_step, the combinational single-iteration shift/compare/subtract cell. It takes R, Q and D and returns the next R and next Q.
- The FSM, counter and output registers stay in seq_divider.

Test Plan:
- Unsigned, dividend=249, divisor=69, start for one cycle: done exactly 17 clocks later with quotient=3, remainder=42, div_by_zero=0. busy is high for 16 cycles.
- Unsigned, 32000/16001: quotient=1, remainder=15999. Then 65535/1 with start in the done cycle: quotient=65535, remainder=0, and no idle gap is needed.
- 100/0: done 1 clock after start with quotient=0xFFFF, remainder=100, div_by_zero=1. The next normal op (e.g. 10/3) clears the flag and gives quotient=3, remainder=1.
- Start 249/69, then pulse start with 7/2 at cycle 5 of RUN: the second request is ignored, the result is 3 rem 42, and only one done pulse occurs.
- Start 249/69, assert rst_n=0 at cycle 8 of RUN: all outputs drop to 0 immediately, no done pulse occurs, and after release a fresh 10/3 completes correctly.
- SIGNED_DIV_EN:
  - -7/2 gives quotient=0xFFFD and remainder=0xFFFF.
  - 0x8000/0xFFFF gives quotient=0x8000, remainder=0, overflow=1.
  - 7/-2 gives quotient=0xFFFD and remainder=1.
